// File: rtl/sig_change_logger.sv
// rtl/sig_change_logger.sv - change monitor logging {mask, data, ts} records into a show-ahead FIFO
// Optional timestamp capture is enabled by defining SIG_CHANGE_LOGGER_TS_EN.
module sig_change_logger #(
  parameter int WIDTH  = 2,
  parameter int DEPTH  = 8,
  parameter int TS_W   = 16,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [WIDTH-1:0]         sig_in,
  output logic                     ev_valid,
  input  logic                     ev_ready,
  output logic [WIDTH-1:0]         ev_mask,
  output logic [WIDTH-1:0]         ev_data,
  output logic [TS_W-1:0]          ev_ts,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_cnt,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
`ifdef SIG_CHANGE_LOGGER_TS_EN
  localparam int REC_W = TS_W + 2 * WIDTH;
`else
  localparam int REC_W = 2 * WIDTH;
`endif

  logic [WIDTH-1:0]  r_prev;
  logic              r_primed;
  logic [AW:0]       r_wr;
  logic [AW:0]       r_rd;
  logic              r_ovf;
  logic [DROP_W-1:0] r_drop;
  logic [REC_W-1:0]  r_mem [DEPTH];

  logic [WIDTH-1:0]  w_chg;
  logic              w_valid;
  logic              w_full;
  logic              w_pop;
  logic              w_push_req;
  logic              w_push;
  logic              w_drop;
  logic [REC_W-1:0]  w_rec_in;
  logic [REC_W-1:0]  w_head;

  assign w_chg      = sig_in ^ r_prev;
  assign w_valid    = (r_wr != r_rd);
  assign w_full     = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_pop      = w_valid && ev_ready;
  assign w_push_req = r_primed && en && (w_chg != '0);
  // A pop at the same edge frees the slot a full FIFO needs for the push.
  assign w_push     = w_push_req && (!w_full || w_pop);
  assign w_drop     = w_push_req && w_full && !w_pop;
  assign w_head     = r_mem[r_rd[AW-1:0]];

`ifdef SIG_CHANGE_LOGGER_TS_EN
  logic [TS_W-1:0] r_ts;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + 1'b1;
    end
  end

  assign w_rec_in = {r_ts, sig_in, w_chg};
  assign ev_ts    = w_valid ? w_head[REC_W-1 -: TS_W] : '0;
`else
  assign w_rec_in = {sig_in, w_chg};
  assign ev_ts    = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prev   <= '0;
      r_primed <= 1'b0;
      r_wr     <= '0;
      r_rd     <= '0;
    end else begin
      r_prev   <= sig_in;
      r_primed <= 1'b1;
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop)  r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end else if (w_drop) begin
      r_ovf  <= 1'b1;
      r_drop <= clr_ovf ? {{(DROP_W-1){1'b0}}, 1'b1}
                        : ((&r_drop) ? r_drop : r_drop + 1'b1);
    end else if (clr_ovf) begin
      r_ovf  <= 1'b0;
      r_drop <= '0;
    end
  end

  // Storage needs no reset: head outputs are gated by ev_valid.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr[AW-1:0]] <= w_rec_in;
  end

  assign ev_valid = w_valid;
  assign ev_mask  = w_valid ? w_head[WIDTH-1:0] : '0;
  assign ev_data  = w_valid ? w_head[2*WIDTH-1:WIDTH] : '0;
  assign level    = r_wr - r_rd;
  assign overflow = r_ovf;
  assign drop_cnt = r_drop;

endmodule

// File: tb/tb_sig_change_logger.sv
// tb/tb_sig_change_logger.sv - scoreboard testbench for sig_change_logger
module tb_sig_change_logger;

  localparam int DEPTH = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] sig_in = 2'b00;
  logic       ev_ready = 1'b0;
  logic       clr_ovf = 1'b0;
  logic       ev_valid;
  logic [1:0] ev_mask;
  logic [1:0] ev_data;
  logic [15:0] ev_ts;
  logic [3:0] level;
  logic       overflow;
  logic [7:0] drop_cnt;

  typedef struct {
    logic [1:0]  mask;
    logic [1:0]  data;
    logic [15:0] ts;
  } rec_t;

  rec_t       q_exp[$];
  logic [1:0] m_prev;
  logic       m_primed;
  logic [15:0] m_ts;
  logic       m_ovf;
  logic [7:0] m_drop;
  int         n_pass = 0;
  int         n_total = 0;

  sig_change_logger #(.WIDTH(2), .DEPTH(DEPTH), .TS_W(16), .DROP_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .sig_in(sig_in),
    .ev_valid(ev_valid), .ev_ready(ev_ready), .ev_mask(ev_mask),
    .ev_data(ev_data), .ev_ts(ev_ts), .level(level),
    .overflow(overflow), .drop_cnt(drop_cnt), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] exp_ts(input logic [15:0] t);
`ifdef SIG_CHANGE_LOGGER_TS_EN
    return t;
`else
    return 16'd0;
`endif
  endfunction

  // Drives one edge from a negedge; pops compare the DUT head with the scoreboard.
  task automatic step(input logic [1:0] s, input logic e, input logic rdy, input logic clr);
    rec_t r;
    logic pop, full, req, drop;
    sig_in = s; en = e; ev_ready = rdy; clr_ovf = clr;
    pop  = (q_exp.size() != 0) && rdy;
    full = (q_exp.size() == DEPTH);
    req  = m_primed && e && ((s ^ m_prev) != 2'b00);
    drop = req && full && !pop;
    if (pop) begin
      r = q_exp.pop_front();
      n_total++;
      if (ev_valid !== 1'b1 || ev_mask !== r.mask || ev_data !== r.data || ev_ts !== r.ts)
        $display("FAIL head_record: got v=%b m=%b d=%b ts=%0d, want v=1 m=%b d=%b ts=%0d",
                 ev_valid, ev_mask, ev_data, ev_ts, r.mask, r.data, r.ts);
      else n_pass++;
    end
    if (req && !drop) q_exp.push_back('{mask: s ^ m_prev, data: s, ts: exp_ts(m_ts)});
    if (drop) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 8'd1 : ((m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 8'd0;
    end
    m_prev = s; m_primed = 1'b1; m_ts = m_ts + 16'd1;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; en = 1'b0; sig_in = 2'b00; ev_ready = 1'b0; clr_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    q_exp.delete();
    m_prev = 2'b00; m_primed = 1'b0; m_ts = 16'd0; m_ovf = 1'b0; m_drop = 8'd0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (ev_valid !== 1'b0 || level !== 4'd0 || ev_mask !== 2'b00 || ev_data !== 2'b00 || ev_ts !== 16'd0)
      $display("FAIL reset_head: got v=%b lvl=%0d m=%b d=%b ts=%0d, want all 0", ev_valid, level, ev_mask, ev_data, ev_ts);
    else n_pass++;
    n_total++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0)
      $display("FAIL reset_ovf: got ovf=%b drop=%0d, want 0 0", overflow, drop_cnt);
    else n_pass++;
  endtask

  task automatic test_idle();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(2'b00, 1'b1, 1'b1, 1'b0);
      n_total++;
      if (ev_valid !== 1'b0 || level !== 4'd0)
        $display("FAIL idle_cycle%0d: got v=%b lvl=%0d, want 0 0", i, ev_valid, level);
      else n_pass++;
    end
  endtask

  task automatic test_two_changes();
    do_reset();
    step(2'b00, 1'b1, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b1, 1'b0);
    step(2'b01, 1'b1, 1'b1, 1'b0);
    n_total++;
    if (ev_valid !== 1'b1 || ev_mask !== 2'b01 || ev_data !== 2'b01 || ev_ts !== exp_ts(16'd3))
      $display("FAIL first_change: got v=%b m=%b d=%b ts=%0d, want v=1 m=01 d=01 ts=%0d",
               ev_valid, ev_mask, ev_data, ev_ts, exp_ts(16'd3));
    else n_pass++;
    step(2'b01, 1'b1, 1'b1, 1'b0);
    step(2'b11, 1'b1, 1'b1, 1'b0);
    n_total++;
    if (ev_valid !== 1'b1 || ev_mask !== 2'b10 || ev_data !== 2'b11 || ev_ts !== exp_ts(16'd5))
      $display("FAIL second_change: got v=%b m=%b d=%b ts=%0d, want v=1 m=10 d=11 ts=%0d",
               ev_valid, ev_mask, ev_data, ev_ts, exp_ts(16'd5));
    else n_pass++;
    step(2'b11, 1'b1, 1'b1, 1'b0);
    n_total++;
    if (ev_valid !== 1'b0 || level !== 4'd0)
      $display("FAIL drained: got v=%b lvl=%0d, want 0 0", ev_valid, level);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    do_reset();
    step(2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (level !== 4'd1 || ev_mask !== 2'b11 || ev_data !== 2'b11)
      $display("FAIL simultaneous: got lvl=%0d m=%b d=%b, want 1 11 11", level, ev_mask, ev_data);
    else n_pass++;
    step(2'b11, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_enable();
    do_reset();
    step(2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b10, 1'b0, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (ev_valid !== 1'b0 || level !== 4'd0)
      $display("FAIL enable_low: got v=%b lvl=%0d, want 0 0", ev_valid, level);
    else n_pass++;
  endtask

  task automatic test_overflow();
    do_reset();
    step(2'b00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(m_prev ^ 2'b01, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (level !== 4'd8 || overflow !== 1'b1 || drop_cnt !== 8'd2)
      $display("FAIL overflow: got lvl=%0d ovf=%b drop=%0d, want 8 1 2", level, overflow, drop_cnt);
    else n_pass++;
    n_total++;
    if (ev_mask !== 2'b01 || ev_data !== 2'b01 || ev_ts !== exp_ts(16'd1))
      $display("FAIL overflow_head: got m=%b d=%b ts=%0d, want 01 01 %0d", ev_mask, ev_data, ev_ts, exp_ts(16'd1));
    else n_pass++;
    step(m_prev ^ 2'b01, 1'b1, 1'b1, 1'b0);
    n_total++;
    if (level !== 4'd8 || drop_cnt !== 8'd2)
      $display("FAIL full_push_pop: got lvl=%0d drop=%0d, want 8 2", level, drop_cnt);
    else n_pass++;
    step(m_prev, 1'b1, 1'b0, 1'b1);
    n_total++;
    if (overflow !== 1'b0 || drop_cnt !== 8'd0)
      $display("FAIL clr_ovf: got ovf=%b drop=%0d, want 0 0", overflow, drop_cnt);
    else n_pass++;
    step(m_prev ^ 2'b10, 1'b1, 1'b0, 1'b1);
    n_total++;
    if (overflow !== 1'b1 || drop_cnt !== 8'd1)
      $display("FAIL clr_vs_drop: got ovf=%b drop=%0d, want 1 1", overflow, drop_cnt);
    else n_pass++;
    for (int i = 0; i < 260; i++) step(m_prev ^ 2'b01, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (drop_cnt !== 8'hFF || drop_cnt !== m_drop)
      $display("FAIL drop_saturate: got drop=%0d, want 255", drop_cnt);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) step(m_prev, 1'b1, 1'b1, 1'b0);
    n_total++;
    if (ev_valid !== 1'b0 || level !== 4'd0 || q_exp.size() != 0)
      $display("FAIL drain_all: got v=%b lvl=%0d, want 0 0", ev_valid, level);
    else n_pass++;
  endtask

  task automatic test_reset_midop();
    do_reset();
    step(2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    step(2'b11, 1'b1, 1'b0, 1'b0);
    step(2'b10, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (level !== 4'd3)
      $display("FAIL pre_reset_level: got %0d, want 3", level);
    else n_pass++;
    do_reset();
    n_total++;
    if (ev_valid !== 1'b0 || level !== 4'd0 || ev_mask !== 2'b00 || ev_data !== 2'b00)
      $display("FAIL midop_reset: got v=%b lvl=%0d m=%b d=%b, want 0 0 00 00", ev_valid, level, ev_mask, ev_data);
    else n_pass++;
    step(2'b10, 1'b1, 1'b1, 1'b0);
    step(2'b10, 1'b1, 1'b1, 1'b0);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    n_total++;
    if (ev_valid !== 1'b1 || ev_mask !== 2'b10 || ev_data !== 2'b00 || ev_ts !== exp_ts(16'd2))
      $display("FAIL post_reset_ts: got v=%b m=%b d=%b ts=%0d, want 1 10 00 %0d",
               ev_valid, ev_mask, ev_data, ev_ts, exp_ts(16'd2));
    else n_pass++;
    step(2'b00, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_idle();
    test_two_changes();
    test_simultaneous();
    test_enable();
    test_overflow();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
